fft32_deadlock_block_detector: RTL
==================================

Name: fft32_deadlock_block_detector

Overview:
- Per-kernel deadlock qualifier; sits directly upstream of the fft32 kernel deadlock monitor top and drives its `block` input.
- Samples the kernel's AXIS block, instance idle and instance block vectors every cycle.
- Asserts `block` only after a blocking signature has held stable for HOLD_CYCLES consecutive cycles.
- Captures the qualifying signature and counts deadlock events for the report logic.

Parameters:
- N_AXIS, 2, number of AXIS block sources (bit i=1: port i stalled by outside world)
- N_INST, 3, number of instance idle flags
- N_BLK, 1, number of instance-level block flags
- HOLD_CYCLES, 16, consecutive stable-candidate cycles required to declare deadlock; legal range >=1
- CNT_W, 8, width of saturating event counter

Ports:
- clock  in  1  kernel monitor clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all state, counters and snapshot
- axis_block_sigs  in  N_AXIS  AXIS stall flags
- inst_idle_sigs  in  N_INST  instance idle flags
- inst_block_sigs  in  N_BLK  instance block flags
- block  out  1  registered deadlock-qualified flag
- block_sig_snap  out  N_AXIS+N_BLK  {inst_block_sigs, axis_block_sigs} latched on BLOCK entry
- block_event_cnt  out  CNT_W  count of BLOCK entries; saturates at all-ones
- state_o  out  2  current FSM state (debug)

Behaviour:
- Definitions:
  - sig = {inst_block_sigs, axis_block_sigs}
  - cand = (|sig) & ~(&inst_idle_sigs); all-idle means the kernel has finished and is never a deadlock
  - sig_q = registered sig
  - hold_cnt width = $clog2(HOLD_CYCLES+1)
- Reset (reset_n=0, asynchronous): state=S_IDLE, hold_cnt=0, sig_q=0, block=0, block_sig_snap=0, block_event_cnt=0.
- clear=1: same values as reset on the next edge; clear overrides every transition below.
- FSM state encoding: S_IDLE=0, S_ARM=1, S_BLOCK=2.
- S_IDLE:
  - cand=1 -> S_ARM, hold_cnt=1, sig_q=sig.
  - If HOLD_CYCLES==1, go straight to S_BLOCK (entry actions below).
- S_ARM:
  - cand=0 -> S_IDLE, hold_cnt=0.
  - cand=1 and sig!=sig_q -> stay, hold_cnt=1, sig_q=sig.
  - cand=1 and sig==sig_q and hold_cnt+1==HOLD_CYCLES -> S_BLOCK.
  - Otherwise hold_cnt+1.
- S_BLOCK entry actions: block=1, block_sig_snap=sig, block_event_cnt += 1 (saturating).
- S_BLOCK:
  - cand=0 -> S_IDLE, block=0, hold_cnt=0.
  - cand=1 and sig!=sig_q -> S_ARM, block=0, hold_cnt=1, sig_q=sig (the new signature must re-qualify).
  - Otherwise hold, block stays 1.
- block_sig_snap holds its value after leaving S_BLOCK until the next entry or clear.
- Latency: block rises on the clock edge that samples the HOLD_CYCLES-th consecutive cycle with cand=1 and an unchanged sig; it falls on the edge that samples cand=0 or a sig change.
- Reset mid-S_BLOCK: block falls immediately (asynchronous).
- Simultaneous cand drop and sig change: cand=0 wins -> S_IDLE.
- Outputs are registered only; no combinational path from inputs to block.

Decomposition:
- Shared package fft32_monitor_pkg holds:
  - state enum (S_IDLE/S_ARM/S_BLOCK, 2-bit)
  - default N_AXIS/N_INST/N_BLK constants for fft32
  - HOLD_CYCLES default
- One natural sub-module: fft32_sat_counter (parameterised width, inc/clear, saturating).
  - Used for block_event_cnt.
  - hold_cnt is inline.

Test Plan:
- Hold to block (HOLD=4): axis_block_sigs=2'b01, inst_idle=3'b010 held 4 cycles -> block=1 on 4th sampling edge, snap=3'b001, event_cnt=1, state_o=2.
- Signature change restarts qualification (HOLD=4): axis=01 for 3 cycles, then 10 for 4 cycles -> block stays 0 for first 6 sampled cycles, rises on 7th edge, snap=3'b010.
- Kernel finished is not a deadlock: inst_idle=3'b111 with axis=2'b11 for 20 cycles -> block=0, state_o=0.
- Deadlock break and re-entry: after block=1, cand drops 1 cycle -> block=0 next edge; cand returns 4 cycles -> block=1, event_cnt=2, snap unchanged in the gap.
- Saturation (CNT_W=2): 5 qualify/break cycles -> event_cnt stops at 3.
- Reset and clear:
  - reset_n low while block=1 -> block=0 with no clock edge; all outputs 0.
  - clear=1 while in S_ARM -> state_o=0 next edge, event_cnt=0.

Source files
------------

// File: rtl/fft32_monitor_pkg.sv
// Shared types and fft32 default sizing for the kernel deadlock monitor slice.
package fft32_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_BLOCK = 2'd2
  } mon_state_t;

  localparam int FFT32_N_AXIS      = 2;
  localparam int FFT32_N_INST      = 3;
  localparam int FFT32_N_BLK       = 1;
  localparam int FFT32_HOLD_CYCLES = 16;

endpackage

// File: rtl/fft32_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module fft32_sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fft32_deadlock_block_detector.sv
// Qualifies a stable blocking signature for HOLD_CYCLES cycles before raising block.
// state   | meaning
// S_IDLE  | no candidate deadlock
// S_ARM   | candidate seen, counting stable cycles of the same signature
// S_BLOCK | deadlock qualified, block asserted
module fft32_deadlock_block_detector
  import fft32_monitor_pkg::*;
#(
  parameter int N_AXIS      = FFT32_N_AXIS,
  parameter int N_INST      = FFT32_N_INST,
  parameter int N_BLK       = FFT32_N_BLK,
  parameter int HOLD_CYCLES = FFT32_HOLD_CYCLES,
  parameter int CNT_W       = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear,
  input  logic [N_AXIS-1:0]         axis_block_sigs,
  input  logic [N_INST-1:0]         inst_idle_sigs,
  input  logic [N_BLK-1:0]          inst_block_sigs,
  output logic                      block,
  output logic [N_AXIS+N_BLK-1:0]   block_sig_snap,
  output logic [CNT_W-1:0]          block_event_cnt,
  output logic [1:0]                state_o
);

  localparam int SIG_W = N_AXIS + N_BLK;
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);
  localparam logic [HC_W-1:0] HOLD_M1 = HC_W'(HOLD_CYCLES - 1);

  mon_state_t        state, state_n;
  logic [HC_W-1:0]   hold_cnt, hold_n;
  logic [SIG_W-1:0]  sig, sig_q, sig_q_n, snap_n;
  logic              block_n;
  logic              cand;
  logic              enter;

  assign sig  = {inst_block_sigs, axis_block_sigs};
  // All instances idle means the kernel finished; never treat that as a deadlock.
  assign cand = (|sig) & ~(&inst_idle_sigs);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      hold_cnt       <= '0;
      sig_q          <= '0;
      block          <= 1'b0;
      block_sig_snap <= '0;
    end else if (clear) begin
      state          <= S_IDLE;
      hold_cnt       <= '0;
      sig_q          <= '0;
      block          <= 1'b0;
      block_sig_snap <= '0;
    end else begin
      state          <= state_n;
      hold_cnt       <= hold_n;
      sig_q          <= sig_q_n;
      block          <= block_n;
      block_sig_snap <= snap_n;
    end
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    sig_q_n = sig_q;
    block_n = block;
    snap_n  = block_sig_snap;
    enter   = 1'b0;
    case (state)
      S_IDLE: begin
        if (cand) begin
          hold_n  = HC_ONE;
          sig_q_n = sig;
          if (HOLD_CYCLES == 1) begin
            state_n = S_BLOCK;
            enter   = 1'b1;
          end else begin
            state_n = S_ARM;
          end
        end
      end
      S_ARM: begin
        if (!cand) begin
          state_n = S_IDLE;
          hold_n  = '0;
        end else if (sig != sig_q) begin
          hold_n  = HC_ONE;
          sig_q_n = sig;
        end else if (hold_cnt >= HOLD_M1) begin
          // Compare against HOLD-1 so hold_cnt+1 can never wrap the counter width.
          state_n = S_BLOCK;
          enter   = 1'b1;
        end else begin
          hold_n = hold_cnt + HC_ONE;
        end
      end
      S_BLOCK: begin
        if (!cand) begin
          state_n = S_IDLE;
          block_n = 1'b0;
          hold_n  = '0;
        end else if (sig != sig_q) begin
          state_n = S_ARM;
          block_n = 1'b0;
          hold_n  = HC_ONE;
          sig_q_n = sig;
        end
      end
      default: begin
        state_n = S_IDLE;
        block_n = 1'b0;
        hold_n  = '0;
      end
    endcase
    if (enter) begin
      block_n = 1'b1;
      snap_n  = sig;
    end
  end

  fft32_sat_counter #(
    .WIDTH (CNT_W)
  ) u_event_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .inc     (enter),
    .count   (block_event_cnt)
  );

  assign state_o = state;

endmodule
